// File: rtl/command_serializer.sv
// Turns one latched command (opcode plus payload) into a byte stream for the
// downstream command receiver. Each byte is held until the receiver acknowledges it.
module command_serializer #(
    parameter int n_blocks       = 256,
    parameter int data_width     = 16,
    parameter int timeout_cycles = 1023,
    localparam int BLOCK_BYTES   = (n_blocks > 256) ? 2 : 1,
    localparam int DATA_BYTES    = (data_width == 24) ? 3 : 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_opcode,
    input  logic [8*BLOCK_BYTES-1:0] cmd_block,
    input  logic [31:0]              cmd_instr,
    input  logic [8*DATA_BYTES-1:0]  cmd_data,
    input  logic [23:0]              cmd_delay_size,
    input  logic [23:0]              cmd_init_delay,
    input  logic                     rx_ready,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     next,
    output logic                     busy,
    output logic                     cmd_done,
    output logic                     cmd_error
);

    localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h01;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_0  = 8'h02;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_1  = 8'h03;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_0 = 8'h04;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_1 = 8'h05;
    localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h06;
    localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h07;
    localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h08;
    localparam logic [7:0] COMMAND_SWAP_PIPELINES     = 8'h09;
    localparam logic [7:0] COMMAND_RESET_PIPELINE     = 8'h0A;
    localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h0B;

    localparam int TIMER_W = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RX,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t               r_state;
    logic [7:0]           r_opcode;
    logic [7:0]           r_out_byte;
    logic                 r_out_valid;
    logic                 r_done;
    logic                 r_error;
    logic [47:0]          r_shift;
    logic [2:0]           r_remaining;
    logic [TIMER_W-1:0]   r_timer;

    logic [47:0]          w_instr_payload;
    logic [47:0]          w_reg_payload;
    logic [47:0]          w_delay_payload;
    logic [47:0]          w_gain_payload;
    logic [47:0]          w_payload;
    logic [2:0]           w_len;
    logic                 w_known;

    // Payload fields are left-aligned so the first byte to send is always [47:40].
    assign w_instr_payload = 48'({cmd_block, cmd_instr}) << (48 - 8*BLOCK_BYTES - 32);
    assign w_reg_payload   = 48'({cmd_block, cmd_data}) << (48 - 8*BLOCK_BYTES - 8*DATA_BYTES);
    assign w_delay_payload = {cmd_delay_size, cmd_init_delay};
    assign w_gain_payload  = 48'(cmd_data) << (48 - 8*DATA_BYTES);

    always_comb begin
        w_known   = 1'b1;
        w_payload = '0;
        w_len     = 3'd0;
        case (cmd_opcode)
            COMMAND_WRITE_BLOCK_INSTR: begin
                w_payload = w_instr_payload;
                w_len     = 3'(BLOCK_BYTES + 4);
            end
            COMMAND_WRITE_BLOCK_REG_0,
            COMMAND_WRITE_BLOCK_REG_1,
            COMMAND_UPDATE_BLOCK_REG_0,
            COMMAND_UPDATE_BLOCK_REG_1: begin
                w_payload = w_reg_payload;
                w_len     = 3'(BLOCK_BYTES + DATA_BYTES);
            end
            COMMAND_ALLOC_DELAY: begin
                w_payload = w_delay_payload;
                w_len     = 3'd6;
            end
            COMMAND_SET_INPUT_GAIN,
            COMMAND_SET_OUTPUT_GAIN: begin
                w_payload = w_gain_payload;
                w_len     = 3'(DATA_BYTES);
            end
            COMMAND_SWAP_PIPELINES,
            COMMAND_RESET_PIPELINE,
            COMMAND_COMMIT_REG_UPDATES: begin
                w_len = 3'd0;
            end
            default: w_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_opcode    <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_shift     <= '0;
            r_remaining <= '0;
            r_timer     <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (w_known) begin
                            r_state     <= ST_WAIT_RX;
                            r_opcode    <= cmd_opcode;
                            r_shift     <= w_payload;
                            r_remaining <= w_len;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RX: begin
                    if (rx_ready) begin
                        r_state     <= ST_SEND;
                        r_out_byte  <= r_opcode;
                        r_out_valid <= 1'b1;
                        r_timer     <= '0;
                    end
                end
                ST_SEND: begin
                    // An acknowledge in the final allowed cycle still completes the byte.
                    if (next) begin
                        r_out_valid <= 1'b0;
                        r_timer     <= '0;
                        if (r_remaining != 3'd0) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_out_valid <= 1'b0;
                        r_error     <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_out_byte  <= r_shift[47:40];
                    r_shift     <= {r_shift[39:0], 8'h00};
                    r_remaining <= r_remaining - 3'd1;
                    r_out_valid <= 1'b1;
                    r_timer     <= '0;
                    r_state     <= ST_SEND;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_byte  = r_out_byte;
    assign out_valid = r_out_valid;
    assign cmd_done  = r_done;
    assign cmd_error = r_error;

endmodule

// File: tb/tb_command_serializer.sv
// Directed bench for command_serializer: a simple receiver model acks bytes and
// each scenario task compares the captured stream and status pulses to hand-derived values.
module tb_command_serializer;

    localparam logic [7:0] OP_WRITE_BLOCK_INSTR  = 8'h01;
    localparam logic [7:0] OP_WRITE_BLOCK_REG_0  = 8'h02;
    localparam logic [7:0] OP_WRITE_BLOCK_REG_1  = 8'h03;
    localparam logic [7:0] OP_UPDATE_BLOCK_REG_1 = 8'h05;
    localparam logic [7:0] OP_ALLOC_DELAY        = 8'h06;
    localparam logic [7:0] OP_SET_INPUT_GAIN     = 8'h07;
    localparam logic [7:0] OP_SWAP_PIPELINES     = 8'h09;
    localparam logic [7:0] OP_COMMIT_REG_UPDATES = 8'h0B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = '0;
    logic [7:0]  cmd_block = '0;
    logic [31:0] cmd_instr = '0;
    logic [15:0] cmd_data = '0;
    logic [23:0] cmd_delay_size = '0;
    logic [23:0] cmd_init_delay = '0;
    logic        rx_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        next = 1'b0;
    logic        busy;
    logic        cmd_done;
    logic        cmd_error;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         run_q[$];
    int         done_cnt, err_cnt, gap_bad, unstable, ready_low, timed_out;

    command_serializer #(
        .n_blocks(256),
        .data_width(16),
        .timeout_cycles(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_block(cmd_block),
        .cmd_instr(cmd_instr),
        .cmd_data(cmd_data),
        .cmd_delay_size(cmd_delay_size),
        .cmd_init_delay(cmd_init_delay),
        .rx_ready(rx_ready),
        .out_byte(out_byte),
        .out_valid(out_valid),
        .next(next),
        .busy(busy),
        .cmd_done(cmd_done),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [7:0] op, input logic [7:0] blk, input logic [31:0] ins,
                         input logic [15:0] dat, input logic [23:0] sz, input logic [23:0] init);
        cmd_opcode     = op;
        cmd_block      = blk;
        cmd_instr      = ins;
        cmd_data       = dat;
        cmd_delay_size = sz;
        cmd_init_delay = init;
        cmd_valid      = 1'b1;
    endtask

    // Receiver model: asserts next in the ack_at-th cycle of each valid byte (0 = never).
    task automatic collect(input int ack_at, input int budget, input int stop_bytes);
        int run = 0;
        int low = 0;
        int tail = -1;
        int cyc = 0;
        bit seen = 0;
        logic [7:0] held = '0;
        got_q.delete();
        run_q.delete();
        done_cnt = 0; err_cnt = 0; gap_bad = 0; unstable = 0; ready_low = 0; timed_out = 0;
        while (1) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            if (cmd_done === 1'b1) done_cnt++;
            if (cmd_error === 1'b1) err_cnt++;
            if (cmd_ready !== 1'b1) ready_low++;
            if (out_valid === 1'b1) begin
                if (run == 0) begin
                    got_q.push_back(out_byte);
                    held = out_byte;
                    if (seen && low != 1) gap_bad++;
                end else if (out_byte !== held) begin
                    unstable++;
                end
                run++;
                low = 0;
                next = (ack_at != 0 && run >= ack_at);
                if (stop_bytes != 0 && got_q.size() == stop_bytes) break;
            end else begin
                if (run != 0) begin
                    run_q.push_back(run);
                    seen = 1;
                end
                run = 0;
                low++;
                next = 1'b0;
            end
            if (tail < 0 && (cmd_done === 1'b1 || cmd_error === 1'b1)) tail = 3;
            else if (tail > 0) tail--;
            if (tail == 0) break;
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
        end
        next = 1'b0;
        $display("txn op=%h bytes=%p done=%0d err=%0d cycles=%0d", cmd_opcode, got_q, done_cnt, err_cnt, cyc);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else pass_cnt++;
        check_cnt++; if (out_byte !== 8'h00) $display("FAIL reset out_byte: got %h expected 00", out_byte); else pass_cnt++;
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready: got %b expected 1", cmd_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else pass_cnt++;
        check_cnt++; if (cmd_done !== 1'b0 || cmd_error !== 1'b0) $display("FAIL reset pulses: got done=%b err=%b expected 0 0", cmd_done, cmd_error); else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_reg_write;
        @(negedge clk);
        issue(OP_WRITE_BLOCK_REG_0, 8'h05, 32'h0, 16'hABCD, 24'h0, 24'h0);
        collect(2, 100, 0);
        exp_q = '{8'h02, 8'h05, 8'hAB, 8'hCD};
        check_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL reg_write length: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cnt++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) pass_cnt++;
            else $display("FAIL reg_write byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        check_cnt++; if (gap_bad !== 0) $display("FAIL reg_write gap: got %0d bad gaps expected 0", gap_bad); else pass_cnt++;
        check_cnt++; if (unstable !== 0) $display("FAIL reg_write stable: got %0d changes expected 0", unstable); else pass_cnt++;
        check_cnt++; if (done_cnt !== 1) $display("FAIL reg_write done: got %0d expected 1", done_cnt); else pass_cnt++;
        check_cnt++; if (err_cnt !== 0) $display("FAIL reg_write error: got %0d expected 0", err_cnt); else pass_cnt++;
        check_cnt++; if (timed_out !== 0) $display("FAIL reg_write budget: got expired expected finish"); else pass_cnt++;
    endtask

    task automatic test_alloc_delay;
        @(negedge clk);
        issue(OP_ALLOC_DELAY, 8'h00, 32'h0, 16'h0, 24'h012345, 24'h000010);
        collect(2, 100, 0);
        exp_q = '{8'h06, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h10};
        check_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL alloc length: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cnt++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) pass_cnt++;
            else $display("FAIL alloc byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        check_cnt++; if (gap_bad !== 0) $display("FAIL alloc gap: got %0d bad gaps expected 0", gap_bad); else pass_cnt++;
        check_cnt++; if (done_cnt !== 1 || err_cnt !== 0) $display("FAIL alloc status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); else pass_cnt++;
    endtask

    task automatic test_wait_rx;
        int bad_valid = 0;
        int bad_busy = 0;
        rx_ready = 1'b0;
        @(negedge clk);
        issue(OP_SWAP_PIPELINES, 8'h00, 32'h0, 16'h0, 24'h0, 24'h0);
        repeat (20) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (out_valid !== 1'b0) bad_valid++;
            if (busy !== 1'b1) bad_busy++;
        end
        check_cnt++; if (bad_valid !== 0) $display("FAIL wait_rx valid: got %0d high cycles expected 0", bad_valid); else pass_cnt++;
        check_cnt++; if (bad_busy !== 0) $display("FAIL wait_rx busy: got %0d low cycles expected 0", bad_busy); else pass_cnt++;
        rx_ready = 1'b1;
        collect(2, 50, 0);
        check_cnt++; if (got_q.size() !== 1 || got_q[0] !== OP_SWAP_PIPELINES) $display("FAIL wait_rx bytes: got %p expected '{09}", got_q); else pass_cnt++;
        check_cnt++; if (done_cnt !== 1 || err_cnt !== 0) $display("FAIL wait_rx status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL wait_rx idle busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_bad_opcode;
        @(negedge clk);
        issue(8'hEE, 8'h12, 32'h0, 16'h3456, 24'h0, 24'h0);
        collect(2, 10, 0);
        check_cnt++; if (got_q.size() !== 0) $display("FAIL bad_op bytes: got %0d expected 0", got_q.size()); else pass_cnt++;
        check_cnt++; if (err_cnt !== 1) $display("FAIL bad_op error: got %0d pulses expected 1", err_cnt); else pass_cnt++;
        check_cnt++; if (done_cnt !== 0) $display("FAIL bad_op done: got %0d expected 0", done_cnt); else pass_cnt++;
        check_cnt++; if (ready_low !== 0) $display("FAIL bad_op ready: got %0d low cycles expected 0", ready_low); else pass_cnt++;
    endtask

    task automatic test_timeout;
        @(negedge clk);
        issue(OP_WRITE_BLOCK_REG_0, 8'h11, 32'h0, 16'h2233, 24'h0, 24'h0);
        collect(0, 40, 0);
        check_cnt++; if (got_q.size() !== 1 || got_q[0] !== OP_WRITE_BLOCK_REG_0) $display("FAIL timeout bytes: got %p expected '{02}", got_q); else pass_cnt++;
        check_cnt++; if (run_q.size() !== 1 || run_q[0] !== 8) $display("FAIL timeout valid_cycles: got %p expected '{8}", run_q); else pass_cnt++;
        check_cnt++; if (err_cnt !== 1 || done_cnt !== 0) $display("FAIL timeout status: got done=%0d err=%0d expected 0 1", done_cnt, err_cnt); else pass_cnt++;
        check_cnt++; if (timed_out !== 0) $display("FAIL timeout budget: got expired expected finish"); else pass_cnt++;
        // Ack lands exactly in the eighth valid cycle of every byte.
        @(negedge clk);
        issue(OP_SET_INPUT_GAIN, 8'h00, 32'h0, 16'h1234, 24'h0, 24'h0);
        collect(8, 100, 0);
        exp_q = '{8'h07, 8'h12, 8'h34};
        check_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL late_ack length: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cnt++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) pass_cnt++;
            else $display("FAIL late_ack byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        check_cnt++; if (run_q.size() !== 3 || run_q[0] !== 8 || run_q[1] !== 8 || run_q[2] !== 8) $display("FAIL late_ack valid_cycles: got %p expected '{8,8,8}", run_q); else pass_cnt++;
        check_cnt++; if (done_cnt !== 1 || err_cnt !== 0) $display("FAIL late_ack status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        @(negedge clk);
        issue(OP_WRITE_BLOCK_INSTR, 8'h22, 32'hDEADBEEF, 16'h0, 24'h0, 24'h0);
        collect(2, 60, 3);
        check_cnt++; if (got_q.size() !== 3 || got_q[2] !== 8'hDE) $display("FAIL rst_mid prefix: got %p expected '{01,22,de}", got_q); else pass_cnt++;
        reset = 1'b0;
        #1;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid out_valid: got %b expected 0", out_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rst_mid state: got busy=%b ready=%b expected 0 1", busy, cmd_ready); else pass_cnt++;
        repeat (3) begin
            @(negedge clk);
            if (cmd_done !== 1'b0 || cmd_error !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        check_cnt++; if (bad !== 0) $display("FAIL rst_mid pulses: got %0d bad cycles expected 0", bad); else pass_cnt++;
        reset = 1'b1;
        issue(OP_WRITE_BLOCK_REG_1, 8'h7F, 32'h0, 16'h0102, 24'h0, 24'h0);
        collect(2, 100, 0);
        exp_q = '{8'h03, 8'h7F, 8'h01, 8'h02};
        check_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL rst_after length: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cnt++;
            if (i < got_q.size() && got_q[i] === exp_q[i]) pass_cnt++;
            else $display("FAIL rst_after byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        check_cnt++; if (done_cnt !== 1 || err_cnt !== 0) $display("FAIL rst_after status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        issue(OP_UPDATE_BLOCK_REG_1, 8'h40, 32'h0, 16'hBEEF, 24'h0, 24'h0);
        collect(1, 100, 0);
        exp_q = '{8'h05, 8'h40, 8'hBE, 8'hEF};
        check_cnt++; if (got_q != exp_q) $display("FAIL b2b first: got %p expected %p", got_q, exp_q); else pass_cnt++;
        check_cnt++; if (run_q.size() !== 4 || run_q[0] !== 1 || run_q[3] !== 1) $display("FAIL b2b valid_cycles: got %p expected '{1,1,1,1}", run_q); else pass_cnt++;
        issue(OP_COMMIT_REG_UPDATES, 8'h00, 32'h0, 16'h0, 24'h0, 24'h0);
        collect(2, 50, 0);
        check_cnt++; if (got_q.size() !== 1 || got_q[0] !== OP_COMMIT_REG_UPDATES) $display("FAIL b2b second: got %p expected '{0b}", got_q); else pass_cnt++;
        check_cnt++; if (done_cnt !== 1 || err_cnt !== 0) $display("FAIL b2b status: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_alloc_delay();
        test_wait_rx();
        test_bad_opcode();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
